reg_window_ctrl: RTL
====================

# reg_window_ctrl

Register-window controller for the SPARC integer register file. It holds the Current Window Pointer (CWP) and the Window Invalid Mask (WIM). It executes SAVE, RESTORE, trap-entry and RETT window moves, and raises window overflow/underflow traps. It sits directly upstream of the 2-to-4 window-select decoder: `WinSel` drives that decoder's select input and `WinLd` drives its load enable.

## Interface
Parameters:
- `NWINDOWS`, 4: number of register windows; must equal 2**`CWP_W`.
- `CWP_W`, 2: CWP width.

Ports:
- `Clk`  in  1  — single clock; all state updates on the rising edge.
- `Clr`  in  1  — reset; asynchronous, active-high.
- `Save`  in  1  — SAVE request; decrement CWP.
- `Restore`  in  1  — RESTORE request; increment CWP.
- `TrapEntry`  in  1  — trap entry; decrement CWP with no WIM check.
- `Rett`  in  1  — return from trap; increment CWP.
- `WrCwp`  in  1  — direct CWP write (WRPSR path).
- `CwpIn`  in  `CWP_W`  — value for `WrCwp`.
- `WrWim`  in  1  — WIM write.
- `WimIn`  in  `NWINDOWS`  — value for `WrWim`.
- `WinSel`  out  `CWP_W`  — registered CWP; select input to the window decoder.
- `WinLd`  out  1  — one-cycle strobe; CWP changed on the previous edge.
- `Wim`  out  `NWINDOWS`  — registered WIM.
- `WinOvf`  out  1  — one-cycle window-overflow trap pulse.
- `WinUnf`  out  1  — one-cycle window-underflow trap pulse.
- `ReqErr`  out  1  — one-cycle pulse for a conflicting request.

## Operation
All CWP arithmetic is modulo `NWINDOWS`. Decrement means (CWP−1) mod N; increment means (CWP+1) mod N.

Per cycle, the highest-priority active request is resolved in this order:
1. `TrapEntry`: CWP ← dec. No WIM check and no trap.
2. `Rett`: target = inc. If `Wim[target]`=1, pulse `WinUnf` and leave CWP unchanged; otherwise CWP ← target.
3. `WrCwp`: CWP ← `CwpIn`. No WIM check.
4. `Save` and `Restore` both asserted: no CWP change; pulse `ReqErr`.
5. `Save` alone: target = dec. If `Wim[target]`=1, pulse `WinOvf` and leave CWP unchanged; otherwise CWP ← target.
6. `Restore` alone: target = inc. If `Wim[target]`=1, pulse `WinUnf` and leave CWP unchanged; otherwise CWP ← target.

Additional rules:
- Any request masked by a higher-priority request is dropped silently.
- `WrWim` is independent of the priority list. It updates `Wim` on the same edge. WIM checks in that cycle use the old WIM.
- `WinLd` is 1 in the cycle after any edge where CWP's value actually changed. It is 0 when CWP is written with an equal value.
- Reset values: `WinSel`=0, `Wim`=0, `WinLd`=0, `WinOvf`=0, `WinUnf`=0, `ReqErr`=0.

## Timing
- Requests are sampled on the rising edge. `WinSel` and `Wim` reflect the request in the cycle after that edge (latency 1).
- `WinOvf`, `WinUnf`, `ReqErr` and `WinLd` are registered. Each is high for exactly one cycle following the sampling edge. They re-pulse each cycle while the request is held.
- There is no handshake: every request is fully resolved in one cycle and back-to-back requests are legal.
- Wrap-around: SAVE from CWP=0 targets N−1; RESTORE from N−1 targets 0.
- `Clr` asserted mid-operation forces all outputs to their reset values immediately. A pending trap pulse is cancelled.

## Configuration
- `WIN_TRAP_CHECK_EN` defined: WIM checks, `WinOvf` and `WinUnf` behave as described above.
- `WIN_TRAP_CHECK_EN` undefined:
  - No WIM checks are performed; `Save`, `Restore` and `Rett` always move CWP.
  - `WinOvf` and `WinUnf` are tied to 0.
  - The `Wim` register and `WrWim` still function.

## Test plan
- Reset: `Clr` pulse mid-cycle → `WinSel`=0 and `Wim`=0 asynchronously; all strobes 0.
- SAVE wrap: CWP=0, `Wim`=4'b0000, `Save` → `WinSel`=3 and `WinLd`=1 for one cycle. Then `Restore` → `WinSel`=0.
- Overflow: `WrWim` with 4'b1000, CWP=0, `Save` → `WinOvf`=1 for one cycle, `WinSel` stays 0, `WinLd`=0. Without the macro: `WinSel`=3 and `WinOvf`=0.
- Underflow: CWP=2, `Wim`=4'b1000, `Rett` → `WinUnf`=1 and `WinSel` stays 2. Then `TrapEntry` → `WinSel`=1, no trap.
- Conflicts:
  - `Save`+`Restore` at CWP=1 → `ReqErr`=1 and `WinSel`=1.
  - `TrapEntry`+`WrCwp`(`CwpIn`=3) at CWP=1 → `WinSel`=0.
- Same-edge WIM: CWP=1, `Wim`=0, `Save`+`WrWim`(4'b0001) in one cycle → `WinSel`=0 with no `WinOvf` (old WIM used); `Wim`=4'b0001.

Source files
------------

// File: rtl/reg_window_ctrl.sv
// Register-window controller: holds CWP and WIM, resolves SAVE/RESTORE/trap/RETT window moves, and raises overflow/underflow traps.
// Latency: 1 cycle. Requests are sampled on the rising edge; CWP, WIM and all strobes are registered outputs.
// Backpressure: none. Every request resolves in one cycle, back-to-back requests are legal, and a strobe re-pulses while its request is held.
//
// Optional feature macro: WIN_TRAP_CHECK_EN
//   defined   : SAVE/RESTORE/RETT targets are checked against WIM; WinOvf/WinUnf pulse on a hit.
//   undefined : no WIM checks, so moves always happen and WinOvf/WinUnf stay 0.
//               The WIM register and its write port are still present.
//
// Ports:
//   Clk, Clr            clock; asynchronous active-high reset
//   Save, Restore       window moves (dec / inc)
//   TrapEntry, Rett     trap entry (dec, unchecked) / return from trap (inc)
//   WrCwp, CwpIn        direct CWP write
//   WrWim, WimIn        WIM write (independent of the move priority)
//   WinSel              registered CWP, feeds the window decoder select
//   WinLd               one-cycle strobe: CWP changed on the previous edge
//   Wim                 registered WIM
//   WinOvf, WinUnf      one-cycle trap pulses
//   ReqErr              one-cycle pulse: Save and Restore requested together
module reg_window_ctrl #(
    parameter int NWINDOWS = 4,
    parameter int CWP_W    = 2
) (
    input  logic                Clk,
    input  logic                Clr,
    input  logic                Save,
    input  logic                Restore,
    input  logic                TrapEntry,
    input  logic                Rett,
    input  logic                WrCwp,
    input  logic [CWP_W-1:0]    CwpIn,
    input  logic                WrWim,
    input  logic [NWINDOWS-1:0] WimIn,
    output logic [CWP_W-1:0]    WinSel,
    output logic                WinLd,
    output logic [NWINDOWS-1:0] Wim,
    output logic                WinOvf,
    output logic                WinUnf,
    output logic                ReqErr
);

    // NWINDOWS must equal 2**CWP_W. Modulo-N arithmetic then reduces to
    // plain CWP_W-bit wrap-around, so no explicit compare is needed.

    logic [CWP_W-1:0]    r_cwp;
    logic [NWINDOWS-1:0] r_wim;
    logic                r_ld;
    logic                r_ovf;
    logic                r_unf;
    logic                r_err;

    logic [CWP_W-1:0]    w_cwp_dec;
    logic [CWP_W-1:0]    w_cwp_inc;
    logic                w_dec_blocked;
    logic                w_inc_blocked;
    logic [CWP_W-1:0]    w_cwp_nxt;
    logic                w_ovf_nxt;
    logic                w_unf_nxt;
    logic                w_err_nxt;

    assign w_cwp_dec = r_cwp - 1'b1;
    assign w_cwp_inc = r_cwp + 1'b1;

`ifdef WIN_TRAP_CHECK_EN
    // WIM checks use the register value from before this edge, even when
    // WrWim is active in the same cycle.
    assign w_dec_blocked = r_wim[w_cwp_dec];
    assign w_inc_blocked = r_wim[w_cwp_inc];
`else
    // With checking disabled, moves are never blocked. The trap flops
    // below therefore hold their reset value of 0 permanently.
    assign w_dec_blocked = 1'b0;
    assign w_inc_blocked = 1'b0;
`endif

    // Priority resolution. Each branch fully resolves the cycle, so any
    // lower-priority request is dropped without a side effect.
    always_comb begin
        w_cwp_nxt = r_cwp;
        w_ovf_nxt = 1'b0;
        w_unf_nxt = 1'b0;
        w_err_nxt = 1'b0;
        if (TrapEntry) begin
            w_cwp_nxt = w_cwp_dec;
        end else if (Rett) begin
            if (w_inc_blocked) begin
                w_unf_nxt = 1'b1;
            end else begin
                w_cwp_nxt = w_cwp_inc;
            end
        end else if (WrCwp) begin
            w_cwp_nxt = CwpIn;
        end else if (Save && Restore) begin
            w_err_nxt = 1'b1;
        end else if (Save) begin
            if (w_dec_blocked) begin
                w_ovf_nxt = 1'b1;
            end else begin
                w_cwp_nxt = w_cwp_dec;
            end
        end else if (Restore) begin
            if (w_inc_blocked) begin
                w_unf_nxt = 1'b1;
            end else begin
                w_cwp_nxt = w_cwp_inc;
            end
        end
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            r_cwp <= '0;
            r_wim <= '0;
            r_ld  <= 1'b0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_cwp <= w_cwp_nxt;
            if (WrWim) begin
                r_wim <= WimIn;
            end
            // WinLd fires only on a real value change. Rewriting CWP with
            // its current value leaves the decoder alone.
            r_ld  <= (w_cwp_nxt != r_cwp);
            r_ovf <= w_ovf_nxt;
            r_unf <= w_unf_nxt;
            r_err <= w_err_nxt;
        end
    end

    assign WinSel = r_cwp;
    assign Wim    = r_wim;
    assign WinLd  = r_ld;
    assign WinOvf = r_ovf;
    assign WinUnf = r_unf;
    assign ReqErr = r_err;

endmodule
